audio_in_capture: RTL and testbench

//  Read-side companion to the synthesizer output path: drains ADC samples from Audio_Controller
//  (audio_in_available/read_audio_in), mixes L/R to mono, optionally decimates, buffers in a FIFO
//  and exposes a pop interface plus peak-level and overflow status to the audio CPU datapath.

---
 rtl/audio_in_capture.sv | 75 +++++++
 tb/tb_audio_in_capture.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/audio_in_capture.sv
// audio_in_capture: drains codec L/R pairs, mixes to mono, decimates, buffers in a FIFO with peak/overflow status
module audio_in_capture #(
  parameter int DEPTH = 16,
  parameter int DECIM = 1
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic                     capture_enable,
  input  logic                     audio_in_available,
  input  logic [31:0]              left_channel_audio_in,
  input  logic [31:0]              right_channel_audio_in,
  output logic                     read_audio_in,
  input  logic                     sample_read,
  output logic [31:0]              sample_data,
  output logic                     sample_valid,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic [31:0]              peak_level,
  input  logic                     clear_status
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = DECIM > 1 ? $clog2(DECIM) : 1;
  typedef enum logic [1:0] {IDLE, ACK, MIX} state_t;
  state_t state, state_nx;
  logic [31:0] l_q, r_q, mono, mag;
  logic [CW-1:0] dcnt;
  logic [AW-1:0] wptr, rptr;
  logic [31:0] mem [DEPTH];
  logic keep, full, pop, store, drop;
  always_comb begin
    state_nx = state == IDLE ? ((capture_enable && audio_in_available) ? ACK : IDLE) :
               state == ACK  ? MIX : IDLE;
    read_audio_in = state == ACK;
    mono = ($signed(l_q) >>> 1) + ($signed(r_q) >>> 1);
    mag = mono == 32'h8000_0000 ? 32'h7FFF_FFFF : mono[31] ? -mono : mono;
    keep = state == MIX && dcnt == '0;
    full = fifo_count == (AW+1)'(DEPTH);
    pop = sample_read && fifo_count != '0;
    store = keep && (!full || pop);
    drop = keep && full && !pop;
  end
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state <= IDLE;
      l_q <= '0;
      r_q <= '0;
      dcnt <= '0;
      wptr <= '0;
      rptr <= '0;
      fifo_count <= '0;
      sample_data <= '0;
      sample_valid <= 1'b0;
      overflow <= 1'b0;
      peak_level <= '0;
    end else begin
      state <= state_nx;
      if (state == ACK) begin
        l_q <= left_channel_audio_in;
        r_q <= right_channel_audio_in;
      end
      if (state == MIX) dcnt <= dcnt == CW'(DECIM-1) ? '0 : dcnt + 1'b1;
      wptr <= wptr + AW'(store);
      rptr <= rptr + AW'(pop);
      fifo_count <= fifo_count + (AW+1)'(store) - (AW+1)'(pop);
      sample_valid <= pop;
      if (pop) sample_data <= mem[rptr];
      overflow <= drop | (overflow & ~clear_status);
      peak_level <= store ? ((clear_status || mag > peak_level) ? mag : peak_level) :
                    clear_status ? '0 : peak_level;
    end
  end
  // storage needs no reset: only entries between the pointers are ever read
  always_ff @(posedge CLOCK_50)
    if (store) mem[wptr] <= mono;
endmodule

// File: tb/tb_audio_in_capture.sv
// tb_audio_in_capture: randomized scoreboard bench with a queue-level reference model
module tb_audio_in_capture;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1, en = 1'b0, avail = 1'b0, sr = 1'b0, clr = 1'b0;
  logic [31:0] lt = '0, rt = '0;
  logic ra, sv, ov;
  logic [31:0] sd, pk;
  logic [4:0] cnt;

  logic av4 = 1'b0, sr4 = 1'b0, go4 = 1'b0;
  logic [31:0] l4 = '0;
  logic ra4, sv4, ov4;
  logic [31:0] sd4, pk4;
  logic [4:0] cnt4;
  int idx4 = 0;
  logic s_ra4 = 1'b0;

  audio_in_capture #(.DEPTH(16), .DECIM(1)) dut (
    .CLOCK_50(clk), .reset(reset), .capture_enable(en), .audio_in_available(avail),
    .left_channel_audio_in(lt), .right_channel_audio_in(rt), .read_audio_in(ra),
    .sample_read(sr), .sample_data(sd), .sample_valid(sv), .fifo_count(cnt),
    .overflow(ov), .peak_level(pk), .clear_status(clr));

  audio_in_capture #(.DEPTH(16), .DECIM(4)) dut4 (
    .CLOCK_50(clk), .reset(reset), .capture_enable(1'b1), .audio_in_available(av4),
    .left_channel_audio_in(l4), .right_channel_audio_in(32'h0), .read_audio_in(ra4),
    .sample_read(sr4), .sample_data(sd4), .sample_valid(sv4), .fifo_count(cnt4),
    .overflow(ov4), .peak_level(pk4), .clear_status(1'b0));

  int total = 0, bad = 0;

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", n, a, e);
    end
  endtask

  function automatic logic [31:0] mono_f(logic [31:0] l, logic [31:0] r);
    return ($signed(l) >>> 1) + ($signed(r) >>> 1);
  endfunction

  function automatic logic [31:0] mag_f(logic [31:0] m);
    if (m == 32'h8000_0000) return 32'h7FFF_FFFF;
    return $signed(m) < 0 ? -m : m;
  endfunction

  logic [63:0] cq[$];
  logic [31:0] mq[$], eq[$];
  logic s_rst = 1'b1, s_sr = 1'b0, s_clr = 1'b0, s_ra = 1'b0;
  logic [31:0] s_l = '0, s_r = '0, pend = '0, m_pk = '0, m_sd = '0;
  bit m_ov = 0, m_sv = 0, m_mix = 0;

  // codec stand-in: presents queued pairs, advances on each acknowledged read
  always @(posedge clk) begin
    #1;
    if (s_ra && cq.size() != 0) void'(cq.pop_front());
    avail = cq.size() != 0;
    if (avail) {lt, rt} = cq[0];
    if (s_ra4) idx4++;
    av4 = go4 && idx4 < 8;
    l4 = 32'((idx4 + 1) * 2);
  end

  // reference model: replays the edge just passed from the previous snapshot
  always @(negedge clk) begin
    if (s_rst) begin
      mq.delete();
      m_pk = '0; m_sd = '0; m_ov = 0; m_sv = 0; m_mix = 0;
    end else begin
      m_sv = s_sr && mq.size() != 0;
      if (m_sv) begin
        m_sd = mq.pop_front();
        eq.push_back(m_sd);
      end
      if (s_clr) begin
        m_ov = 0;
        m_pk = '0;
      end
      if (m_mix) begin
        if (mq.size() < 16) begin
          mq.push_back(pend);
          if (mag_f(pend) > m_pk) m_pk = mag_f(pend);
        end else m_ov = 1;
      end
      m_mix = s_ra;
      pend = mono_f(s_l, s_r);
    end
    chk("count", 32'(cnt), 32'(mq.size()));
    chk("overflow", 32'(ov), 32'(m_ov));
    chk("peak", pk, m_pk);
    chk("valid", 32'(sv), 32'(m_sv));
    if (!m_sv) chk("hold", sd, m_sd);
    if (s_ra) chk("ra_pulse", 32'(ra), 32'h0);
    s_rst = reset; s_sr = sr; s_clr = clr; s_ra = ra; s_l = lt; s_r = rt;
    s_ra4 = ra4;
  end

  // scoreboard monitor: every sample_valid strobe consumes one expected sample
  always @(negedge clk) begin
    #1;
    if (sv) begin
      if (eq.size() == 0) begin
        total++; bad++;
        $display("FAIL data unexpected_strobe got=%h", sd);
      end else chk("data", sd, eq.pop_front());
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle;
    int b = 0;
    while (cq.size() != 0 && b < 300) begin tick; b++; end
    total++;
    if (cq.size() != 0) begin bad++; $display("FAIL idle_timeout got=%0d exp=0", cq.size()); end
    repeat (4) tick;
  endtask

  task automatic wait_ra;
    int b = 0;
    while (!ra && b < 50) begin tick; b++; end
    total++;
    if (!ra) begin bad++; $display("FAIL ack_timeout got=0 exp=1"); end
  endtask

  task automatic drain;
    sr = 1'b1;
    repeat (20) tick;
    sr = 1'b0;
    tick;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

  initial begin
    repeat (3) tick;
    chk("rst_data", sd, 32'h0);
    chk("rst_ra", 32'(ra), 32'h0);
    reset = 1'b0;
    en = 1'b1;
    tick;
    // single pair, mono 0x2000
    cq.push_back({32'h0000_1000, 32'h0000_3000});
    wait_idle;
    chk("t1_count", 32'(cnt), 32'h1);
    chk("t1_peak", pk, 32'h0000_2000);
    // most-negative mix saturates the peak magnitude
    cq.push_back({32'h8000_0000, 32'h8000_0000});
    wait_idle;
    chk("sat_peak", pk, 32'h7FFF_FFFF);
    drain;
    clr = 1'b1; tick; clr = 1'b0; tick;
    chk("clr_peak", pk, 32'h0);
    // fill past full
    for (int i = 0; i < 17; i++) cq.push_back({$urandom, $urandom});
    wait_idle;
    chk("full_count", 32'(cnt), 32'd16);
    chk("full_ovf", 32'(ov), 32'h1);
    clr = 1'b1; tick; clr = 1'b0; tick;
    chk("clr_ovf", 32'(ov), 32'h0);
    chk("clr_pk", pk, 32'h0);
    // push and pop on the same edge while full
    cq.push_back({32'h1234_5678, 32'hFEDC_BA98});
    wait_ra;
    tick;
    sr = 1'b1; tick; sr = 1'b0; tick;
    chk("fullpp_count", 32'(cnt), 32'd16);
    chk("fullpp_ovf", 32'(ov), 32'h0);
    drain;
    // decimate-by-4 instance: pairs give mono 1..8
    go4 = 1'b1;
    for (int b = 0; b < 100 && idx4 < 8; b++) tick;
    repeat (4) tick;
    go4 = 1'b0;
    chk("d4_count", 32'(cnt4), 32'h2);
    chk("d4_peak", pk4, 32'h5);
    sr4 = 1'b1; tick;
    chk("d4_first", sd4, 32'h1);
    chk("d4_valid", 32'(sv4), 32'h1);
    tick;
    chk("d4_second", sd4, 32'h5);
    sr4 = 1'b0; tick;
    chk("d4_empty", 32'(cnt4), 32'h0);
    chk("d4_novalid", 32'(sv4), 32'h0);
    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      en = $urandom_range(0, 9) != 0;
      sr = $urandom_range(0, 2) == 0;
      clr = $urandom_range(0, 30) == 0;
      if ($urandom_range(0, 2) == 0 && cq.size() < 4)
        cq.push_back($urandom_range(0, 7) == 0 ? {32'h8000_0000, $urandom} : {$urandom, $urandom});
      tick;
    end
    en = 1'b1; sr = 1'b0; clr = 1'b0;
    wait_idle;
    drain;
    // reset while acknowledging: pair discarded
    cq.push_back({32'h0100_0000, 32'h0100_0000});
    wait_ra;
    reset = 1'b1; tick; reset = 1'b0;
    chk("rstack_count", 32'(cnt), 32'h0);
    chk("rstack_ra", 32'(ra), 32'h0);
    chk("rstack_peak", pk, 32'h0);
    chk("rstack_valid", 32'(sv), 32'h0);
    repeat (5) tick;
    chk("rstack_nopush", 32'(cnt), 32'h0);
    total++;
    if (eq.size() != 0) begin bad++; $display("FAIL leftover got=%0d exp=0", eq.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
